// File: rtl/case_3_mul_pkg.sv
// Shared widths, tag sizing and pipeline stage record for the case_3 shared
// multiplier arbiter.
package case_3_mul_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int A_W         = 11;
  localparam int B_W         = 10;
  localparam int P_W         = 12;
  localparam int ID_MAX_W    = 3;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
    logic [P_W-1:0]      data;
  } stage_t;

endpackage

// File: rtl/case_3_mul_share_arb_if.sv
// Request/response bundle between the case_3 loop kernels and the shared
// multiplier arbiter.
interface case_3_mul_share_arb_if
  import case_3_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]     req_vld;
  logic [NUM_REQ-1:0]     req_rdy;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_vld;
  logic                   rsp_rdy;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_data;

  modport master (
    output req_vld, req_a, req_b, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_data
  );

  modport slave (
    input  req_vld, req_a, req_b, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_data
  );

endinterface

// File: rtl/case_3_mul_11s_10s_12_1_1.sv
// Signed din0 x din1 multiplier keeping the low dout_WIDTH bits of the product
// (two's-complement wrap, no saturation).
module case_3_mul_11s_10s_12_1_1 #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 12
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Low bits of a signed product depend only on the low operand bits, so
  // evaluating at the output width gives the same bits as the full product.
  assign dout = dout_WIDTH'($signed(din0) * $signed(din1));

endmodule

// File: rtl/case_3_rr_arb.sv
// Rotating-priority encoder: first asserted req at or after ptr wins, and
// gnt is one-hot only while en is high.
module case_3_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[IDW'(idx)]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
    if (en && found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/case_3_mul_share_arb.sv
// Time-shares one signed 11x10 -> 12-bit multiplier among NUM_REQ requesters
// with round-robin grants and an in-order tagged response channel.
module case_3_mul_share_arb
  import case_3_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 1,
  parameter int ID_W        = id_w(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  case_3_mul_share_arb_if.slave  bus,
  output logic                   busy
);

  logic                   adv;
  logic                   acc;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_id;
  logic [ID_W-1:0]        rr_ptr;

  logic                   vld_p0;
  logic [ID_W-1:0]        id_p0;
  logic signed [A_W-1:0]  a_p0;
  logic signed [B_W-1:0]  b_p0;
  logic [P_W-1:0]         mul_dout;

  stage_t                 pipe_pn [PIPE_STAGES];
  stage_t                 out_pn;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  assign out_pn = pipe_pn[PIPE_STAGES-1];
  assign adv    = ~out_pn.vld | bus.rsp_rdy;

  // Grants are masked during reset so req_rdy reads zero while held in reset.
  case_3_rr_arb #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req    (bus.req_vld),
    .ptr    (rr_ptr),
    .en     (adv & ap_rst_n),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req_rdy = gnt;
  assign acc         = |(bus.req_vld & gnt);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (acc) begin
      rr_ptr <= next_ptr(gnt_id);
    end
  end

  // ---- stage p0: granted operands ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p0 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= acc;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (adv && acc) begin
      id_p0 <= gnt_id;
      a_p0  <= bus.req_a[gnt_id*A_W +: A_W];
      b_p0  <= bus.req_b[gnt_id*B_W +: B_W];
    end
  end

  case_3_mul_11s_10s_12_1_1 #(
    .din0_WIDTH (A_W),
    .din1_WIDTH (B_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .din0 (a_p0),
    .din1 (b_p0),
    .dout (mul_dout)
  );

  // ---- stages p1..pN: product registers, last one drives the response ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_pn[i] <= '0;
    end else if (adv) begin
      pipe_pn[0] <= '{vld: vld_p0, id: ID_MAX_W'(id_p0), data: mul_dout};
      for (int i = 1; i < PIPE_STAGES; i++) pipe_pn[i] <= pipe_pn[i-1];
    end
  end

  assign bus.rsp_vld  = out_pn.vld;
  assign bus.rsp_id   = ID_W'(out_pn.id);
  assign bus.rsp_data = out_pn.data;

  always_comb begin
    busy = vld_p0;
    for (int i = 0; i < PIPE_STAGES; i++) busy = busy | pipe_pn[i].vld;
  end

endmodule
